// File: rtl/mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// mem_access_ctrl
//   Initiator side of the word-addressed memory interface. Takes one read or
//   write request at a time from the CPU control unit (MAR/MDR path), presents
//   address/data to the memory one cycle before the strobe, holds them stable
//   while the strobe is active, captures read data and signals completion with
//   a single-cycle done pulse. Out-of-range addresses complete immediately with
//   err and never touch the memory.
//
// Ports
//   clock         in   1       system clock, rising edge
//   reset_n       in   1       asynchronous active-low reset
//   req           in   1       request, sampled only while idle
//   wr            in   1       1 = write, 0 = read (sampled with req)
//   addr          in   ADDR_W  word address (sampled with req)
//   wdata         in   DATA_W  write data (sampled with req)
//   busy          out  1       high whenever a request is in flight
//   done          out  1       one-cycle completion pulse
//   err           out  1       high with done for an out-of-range address
//   rdata         out  DATA_W  last read data, held until the next read completes
//   mem_address   out  ADDR_W  address to memory
//   mem_data_in   out  DATA_W  write data to memory
//   mem_read      out  1       memory read strobe
//   mem_write     out  1       memory write strobe
//   mem_data_out  in   DATA_W  read data from memory
// -----------------------------------------------------------------------------
module mem_access_ctrl #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int DEPTH       = 512,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_in,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_data_out
);

  // The counter only has to reach WAIT_CYCLES-1; keep at least one bit.
  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  CNT_LOAD   = CNT_W'(WAIT_CYCLES - 1);
  localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETUP  = 3'd1,
    S_ACCESS = 3'd2,
    S_DONE   = 3'd3,
    S_ERR    = 3'd4
  } state_e;

  state_e            state_q,   state_d;
  logic [CNT_W-1:0]  cnt_q,     cnt_d;
  logic              wr_q,      wr_d;
  logic              busy_q,    busy_d;
  logic              done_q,    done_d;
  logic              err_q,     err_d;
  logic [DATA_W-1:0] rdata_q,   rdata_d;
  logic [ADDR_W-1:0] maddr_q,   maddr_d;
  logic [DATA_W-1:0] mwdata_q,  mwdata_d;
  logic              mrd_q,     mrd_d;
  logic              mwr_q,     mwr_d;

  logic addr_in_range;
  assign addr_in_range = (addr < ADDR_LIMIT);

  // Every output is a flop; the next-state logic computes the value each
  // output must carry in the coming state, so strobes cannot glitch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wr_d     = wr_q;
    rdata_d  = rdata_q;
    maddr_d  = maddr_q;
    mwdata_d = mwdata_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    mrd_d    = 1'b0;
    mwr_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req) begin
          wr_d     = wr;
          maddr_d  = addr;
          mwdata_d = wdata;
          if (addr_in_range) begin
            state_d = S_SETUP;
          end else begin
            // Illegal address: complete straight away, memory untouched.
            state_d = S_ERR;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end
        end
      end

      S_SETUP: begin
        // Address/data have been stable for a cycle; raise the strobe now.
        state_d = S_ACCESS;
        cnt_d   = CNT_LOAD;
        mrd_d   = ~wr_q;
        mwr_d   = wr_q;
      end

      S_ACCESS: begin
        if (cnt_q == '0) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          if (!wr_q) begin
            rdata_d = mem_data_out;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
          mrd_d = ~wr_q;
          mwr_d = wr_q;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      S_ERR: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      wr_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      maddr_q  <= '0;
      mwdata_q <= '0;
      mrd_q    <= 1'b0;
      mwr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wr_q     <= wr_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
      maddr_q  <= maddr_d;
      mwdata_q <= mwdata_d;
      mrd_q    <= mrd_d;
      mwr_q    <= mwr_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;
  assign rdata       = rdata_q;
  assign mem_address = maddr_q;
  assign mem_data_in = mwdata_q;
  assign mem_read    = mrd_q;
  assign mem_write   = mwr_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_access_ctrl
//   Two controllers (WAIT_CYCLES=1 and WAIT_CYCLES=3) receive the same request
//   stream; each has its own 512-word memory. A word-level reference model
//   (refmem plus expected rdata per controller) predicts what every request
//   must produce: strobe type and length, done timing, err, and read data.
// -----------------------------------------------------------------------------
module tb_mem_access_ctrl;

  localparam int DEPTH = 512;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  logic req     = 1'b0;
  logic wr      = 1'b0;
  logic [31:0] addr  = '0;
  logic [31:0] wdata = '0;

  logic [1:0]        busy_o, done_o, err_o, mrd_o, mwr_o;
  logic [1:0][31:0]  rdata_o, maddr_o, mdi_o;
  logic [31:0]       mdo0, mdo1;

  logic [31:0] mem0   [DEPTH];
  logic [31:0] mem1   [DEPTH];
  logic [31:0] refmem [DEPTH];
  logic [31:0] exp_rdata [2];

  logic        bd_we   = 1'b0;
  logic [8:0]  bd_addr = '0;
  logic [31:0] bd_data = '0;

  int n_pass   = 0;
  int n_fail   = 0;
  int n_checks = 0;

  always #5 clock = ~clock;

  mem_access_ctrl #(.DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH), .WAIT_CYCLES(1)) u_dut0 (
    .clock(clock), .reset_n(reset_n), .req(req), .wr(wr), .addr(addr), .wdata(wdata),
    .busy(busy_o[0]), .done(done_o[0]), .err(err_o[0]), .rdata(rdata_o[0]),
    .mem_address(maddr_o[0]), .mem_data_in(mdi_o[0]), .mem_read(mrd_o[0]),
    .mem_write(mwr_o[0]), .mem_data_out(mdo0)
  );

  mem_access_ctrl #(.DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH), .WAIT_CYCLES(3)) u_dut1 (
    .clock(clock), .reset_n(reset_n), .req(req), .wr(wr), .addr(addr), .wdata(wdata),
    .busy(busy_o[1]), .done(done_o[1]), .err(err_o[1]), .rdata(rdata_o[1]),
    .mem_address(maddr_o[1]), .mem_data_in(mdi_o[1]), .mem_read(mrd_o[1]),
    .mem_write(mwr_o[1]), .mem_data_out(mdo1)
  );

  // Memories: backdoor load has priority, otherwise the controller writes.
  assign mdo0 = mem0[maddr_o[0][8:0]];
  assign mdo1 = mem1[maddr_o[1][8:0]];

  always @(posedge clock) begin
    if (bd_we) begin
      mem0[bd_addr] <= bd_data;
      mem1[bd_addr] <= bd_data;
    end else begin
      if (mwr_o[0]) mem0[maddr_o[0][8:0]] <= mdi_o[0];
      if (mwr_o[1]) mem1[maddr_o[1][8:0]] <= mdi_o[1];
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] init_word(input int i);
    case (i)
      43:      return 32'h2;
      87:      return 32'h3;
      95:      return 32'hD;
      default: return 32'(i) * 32'h9E37_79B1 + 32'h1357;
    endcase
  endfunction

  task automatic backdoor(input int a, input logic [31:0] d);
    bd_we = 1'b1; bd_addr = 9'(a); bd_data = d;
    refmem[a] = d;
    @(negedge clock);
    bd_we = 1'b0;
  endtask

  // One request to both controllers; observes 12 cycles after the accepting
  // edge and compares against what the model says each must have done.
  task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d, input string tag);
    int   done_at [2];
    int   ndone   [2];
    int   nrd     [2];
    int   nwr     [2];
    logic errv    [2];
    logic stable  [2];
    logic busy0   [2];
    logic idle_af [2];
    logic legal;
    int   wc;
    legal = (a < DEPTH);
    for (int k = 0; k < 2; k++) begin
      done_at[k] = -1; ndone[k] = 0; nrd[k] = 0; nwr[k] = 0;
      errv[k] = 1'bx; stable[k] = 1'b1; busy0[k] = 1'b0; idle_af[k] = 1'b0;
    end
    @(negedge clock);
    req = 1'b1; wr = w; addr = a; wdata = d;
    @(negedge clock);
    req = 1'b0; wr = $urandom_range(0, 1); addr = $urandom; wdata = $urandom;
    for (int i = 0; i < 12; i++) begin
      for (int k = 0; k < 2; k++) begin
        if (i == 0) busy0[k] = busy_o[k];
        if (mrd_o[k]) nrd[k]++;
        if (mwr_o[k]) nwr[k]++;
        if ((mrd_o[k] || mwr_o[k]) && (maddr_o[k] !== a || (w && mdi_o[k] !== d)))
          stable[k] = 1'b0;
        if (done_o[k]) begin
          ndone[k]++;
          if (done_at[k] < 0) begin
            done_at[k] = i;
            errv[k]    = err_o[k];
            if (maddr_o[k] !== a) stable[k] = 1'b0;
          end
        end
        if (done_at[k] >= 0 && i == done_at[k] + 1) idle_af[k] = ~busy_o[k];
      end
      @(negedge clock);
    end
    for (int k = 0; k < 2; k++) begin
      wc = (k == 0) ? 1 : 3;
      if (legal && !w) exp_rdata[k] = refmem[a[8:0]];
      check($sformatf("%s/w%0d/busy_at_accept", tag, wc), 64'(busy0[k]), 64'd1);
      check($sformatf("%s/w%0d/done_cycle", tag, wc), 64'(done_at[k]), legal ? 64'(wc + 1) : 64'd0);
      check($sformatf("%s/w%0d/done_pulses", tag, wc), 64'(ndone[k]), 64'd1);
      check($sformatf("%s/w%0d/err", tag, wc), 64'(errv[k]), 64'(!legal));
      check($sformatf("%s/w%0d/read_cycles", tag, wc), 64'(nrd[k]), (legal && !w) ? 64'(wc) : 64'd0);
      check($sformatf("%s/w%0d/write_cycles", tag, wc), 64'(nwr[k]), (legal && w) ? 64'(wc) : 64'd0);
      check($sformatf("%s/w%0d/addr_data_stable", tag, wc), 64'(stable[k]), 64'd1);
      check($sformatf("%s/w%0d/idle_after_done", tag, wc), 64'(idle_af[k]), 64'd1);
      check($sformatf("%s/w%0d/rdata", tag, wc), 64'(rdata_o[k]), 64'(exp_rdata[k]));
    end
    if (legal && w) refmem[a[8:0]] = d;
  endtask

  initial begin
    int   nrd4;
    logic d2, b3, b4, seen;
    logic [31:0] ra, rd;
    logic        rw;

    // Load memories while the controllers are held in reset.
    reset_n = 1'b0;
    for (int i = 0; i < DEPTH; i++) backdoor(i, init_word(i));
    exp_rdata[0] = '0;
    exp_rdata[1] = '0;

    for (int k = 0; k < 2; k++) begin
      check($sformatf("reset/%0d/busy", k),  64'(busy_o[k]),  64'd0);
      check($sformatf("reset/%0d/done", k),  64'(done_o[k]),  64'd0);
      check($sformatf("reset/%0d/err", k),   64'(err_o[k]),   64'd0);
      check($sformatf("reset/%0d/strobes", k), 64'({mrd_o[k], mwr_o[k]}), 64'd0);
      check($sformatf("reset/%0d/rdata", k), 64'(rdata_o[k]), 64'd0);
      check($sformatf("reset/%0d/maddr", k), 64'(maddr_o[k]), 64'd0);
      check($sformatf("reset/%0d/mdata", k), 64'(mdi_o[k]),   64'd0);
    end
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    // Directed requests, including the address boundaries.
    txn(1'b0, 32'd43,  32'h0,     "rd43");
    txn(1'b1, 32'd100, 32'h1234,  "wr100");
    txn(1'b0, 32'd100, 32'h0,     "rd100");
    txn(1'b0, 32'd600, 32'h0,     "rd600");
    txn(1'b1, 32'd600, 32'hBEEF,  "wr600");
    txn(1'b0, 32'd95,  32'h0,     "rd95");
    txn(1'b0, 32'd511, 32'h0,     "rd511");
    txn(1'b0, 32'd512, 32'h0,     "rd512");
    txn(1'b1, 32'h8000_0005, 32'h55, "wr_hi");
    txn(1'b0, 32'd5,   32'h0,     "rd5");
    txn(1'b1, 32'd511, 32'hCAFE_F00D, "wr511");
    txn(1'b0, 32'd511, 32'h0,     "rd511b");

    // req held high: single access, re-accepted only one idle cycle after done.
    nrd4 = 0; d2 = 1'b0; b3 = 1'b1; b4 = 1'b0;
    @(negedge clock);
    req = 1'b1; wr = 1'b0; addr = 32'd87; wdata = '0;
    @(negedge clock);
    for (int i = 0; i < 5; i++) begin
      if (i <= 2 && mrd_o[0]) nrd4++;
      if (i == 2) d2 = done_o[0];
      if (i == 3) b3 = busy_o[0];
      if (i == 4) b4 = busy_o[0];
      if (i == 4) req = 1'b0;
      else @(negedge clock);
    end
    for (int i = 0; i < 12; i++) @(negedge clock);
    exp_rdata[0] = refmem[87];
    exp_rdata[1] = refmem[87];
    check("hold/read_cycles", 64'(nrd4), 64'd1);
    check("hold/done", 64'(d2), 64'd1);
    check("hold/idle_gap", 64'(b3), 64'd0);
    check("hold/reaccept", 64'(b4), 64'd1);
    check("hold/rdata_w1", 64'(rdata_o[0]), 64'd3);
    check("hold/rdata_w3", 64'(rdata_o[1]), 64'd3);

    // Reset in the middle of a write access.
    @(negedge clock);
    req = 1'b1; wr = 1'b1; addr = 32'd51; wdata = 32'hDEAD_0051;
    @(negedge clock);
    req = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 5 && !seen; i++) begin
      if (mwr_o === 2'b11) seen = 1'b1;
      else @(negedge clock);
    end
    check("rst_mid/strobe_seen", 64'(seen), 64'd1);
    reset_n = 1'b0;
    #1;
    check("rst_mid/strobes", 64'({mrd_o, mwr_o}), 64'd0);
    check("rst_mid/busy",    64'(busy_o), 64'd0);
    check("rst_mid/done",    64'(done_o), 64'd0);
    check("rst_mid/rdata0",  64'(rdata_o[0]), 64'd0);
    check("rst_mid/rdata1",  64'(rdata_o[1]), 64'd0);
    exp_rdata[0] = '0;
    exp_rdata[1] = '0;
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    check("rst_mid/no_retry", 64'({busy_o, mrd_o, mwr_o}), 64'd0);
    backdoor(51, 32'h5151_5151);
    txn(1'b0, 32'd51, 32'h0, "rd51");

    // Randomised traffic; occasionally a full-width (usually illegal) address.
    for (int n = 0; n < 24; n++) begin
      rw = 1'($urandom_range(0, 1));
      ra = ($urandom_range(0, 5) == 0) ? $urandom : 32'($urandom_range(0, DEPTH - 1));
      rd = $urandom;
      txn(rw, ra, rd, $sformatf("rnd%0d", n));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
